// File: rtl/vga_frame_monitor_pkg.sv
// Shared constants for the XGA frame monitor: nominal timing, counter widths,
// CRC-16-CCITT parameters and the FSM state encoding.
package vga_frame_monitor_pkg;

    localparam int XGA_H_ACTIVE     = 1024;
    localparam int XGA_H_TOTAL      = 1344;
    localparam int XGA_H_SYNC_START = 1048;
    localparam int XGA_V_ACTIVE     = 768;
    localparam int XGA_V_TOTAL      = 806;
    localparam int XGA_V_SYNC_START = 771;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int HPER_W = 12;
    localparam int LCNT_W = 11;
    localparam int PIX_W  = 20;
    localparam int RGB_W  = 12;
    localparam int CRC_W  = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef logic [1:0] state_t;
    localparam state_t ST_SEARCH = 2'd0;
    localparam state_t ST_ALIGN  = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/vga_frame_monitor_if.sv
// Pin-level video bus observed by the monitor plus the monitor's status outputs.
interface vga_frame_monitor_if;
    import vga_frame_monitor_pkg::*;

    logic             hs_in;
    logic             vs_in;
    logic [RGB_W-1:0] rgb_in;
    logic             locked;
    logic             frame_valid;
    logic [CRC_W-1:0] frame_crc;
    logic [PIX_W-1:0] pixel_count;
    logic             err_h;
    logic             err_v;

    modport master (
        output hs_in, vs_in, rgb_in,
        input  locked, frame_valid, frame_crc, pixel_count, err_h, err_v
    );

    modport slave (
        input  hs_in, vs_in, rgb_in,
        output locked, frame_valid, frame_crc, pixel_count, err_h, err_v
    );

endinterface

// File: rtl/vga_frame_monitor_crc16_12b_step.sv
// One CRC-16-CCITT update over a 12-bit pixel, MSB first, no reflection.
module vga_frame_monitor_crc16_12b_step
    import vga_frame_monitor_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [RGB_W-1:0] data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] c;

    always_comb begin
        // NOTE: blocking assignments let the 12 shift steps chain within one evaluation.
        c = crc_in;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ data_in[i]) ? CRC_POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side video monitor: rebuilds raster position from sync edges, checks
// line/frame periods, and reports a per-frame CRC and pixel count of active video.
module vga_frame_monitor
    import vga_frame_monitor_pkg::*;
#(
    parameter int H_ACTIVE     = XGA_H_ACTIVE,
    parameter int H_TOTAL      = XGA_H_TOTAL,
    parameter int H_SYNC_START = XGA_H_SYNC_START,
    parameter int V_ACTIVE     = XGA_V_ACTIVE,
    parameter int V_TOTAL      = XGA_V_TOTAL,
    parameter int V_SYNC_START = XGA_V_SYNC_START,
    parameter bit SYNC_POL     = 1'b1
) (
    input logic                pclk,
    input logic                rst,
    vga_frame_monitor_if.slave bus
);

    localparam logic [HCNT_W-1:0] H_ACT_C   = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_LAST_C  = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_SYNC_C  = HCNT_W'(H_SYNC_START);
    localparam logic [VCNT_W-1:0] V_ACT_C   = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LAST_C  = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_SYNC_C  = VCNT_W'(V_SYNC_START);
    localparam logic [HPER_W-1:0] H_PER_C   = HPER_W'(H_TOTAL);
    localparam logic [LCNT_W-1:0] V_LINES_C = LCNT_W'(V_TOTAL);

    logic             hs_s_q, hs_s_d, vs_s_q, vs_s_d;
    logic [RGB_W-1:0] rgb_s_q, rgb_s_d, rgb_a_q, rgb_a_d;
    logic             hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [HCNT_W-1:0] hcount_q, hcount_d;
    logic [VCNT_W-1:0] vcount_q, vcount_d;
    logic [HPER_W-1:0] h_per_q, h_per_d;
    logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             hs_seen_q, hs_seen_d;
    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_next;
    logic [PIX_W-1:0] pix_acc_q, pix_acc_d;
    logic             locked_q, locked_d, frame_valid_q, frame_valid_d;
    logic             err_h_q, err_h_d, err_v_q, err_v_d;
    logic [CRC_W-1:0] frame_crc_q, frame_crc_d;
    logic [PIX_W-1:0] pixel_count_q, pixel_count_d;
    logic             hs_act, vs_act, hs_edge, vs_edge, h_wrap, active, h_bad, line_ok, capture;

    vga_frame_monitor_crc16_12b_step u_crc (
        .crc_in  (crc_q),
        .data_in (rgb_a_q),
        .crc_out (crc_next)
    );

    // rgb_a is delayed one more stage so hcount/vcount describe the pixel it holds.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch can be inferred.
        hs_s_d    = bus.hs_in;
        vs_s_d    = bus.vs_in;
        rgb_s_d   = bus.rgb_in;
        rgb_a_d   = rgb_s_q;
        hs_act    = (hs_s_q == SYNC_POL);
        vs_act    = (vs_s_q == SYNC_POL);
        hs_prev_d = hs_act;
        vs_prev_d = vs_act;
        hs_edge   = hs_act && !hs_prev_q;
        vs_edge   = vs_act && !vs_prev_q;
        h_wrap    = !hs_edge && (hcount_q == H_LAST_C);
        active    = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);

        hcount_d = hs_edge ? H_SYNC_C : (h_wrap ? '0 : hcount_q + 1'b1);
        vcount_d = vcount_q;
        if (vs_edge)     vcount_d = V_SYNC_C;
        else if (h_wrap) vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + 1'b1;

        h_per_d = hs_edge ? HPER_W'(1) : ((h_per_q == '1) ? h_per_q : h_per_q + 1'b1);
        line_cnt_d = line_cnt_q;
        if (vs_edge)                          line_cnt_d = LCNT_W'(hs_edge);
        else if (hs_edge && line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;

        crc_d     = vs_edge ? CRC_INIT : (active ? crc_next : crc_q);
        pix_acc_d = vs_edge ? '0 : (active ? pix_acc_q + 1'b1 : pix_acc_q);
    end

    always_comb begin
        h_bad     = hs_edge && hs_seen_q && (h_per_q != H_PER_C);
        line_ok   = (line_cnt_q == V_LINES_C);
        hs_seen_d = (state_q == ST_SEARCH) ? 1'b0 : (hs_seen_q || hs_edge);
        state_d   = state_q;
        err_h_d   = err_h_q;
        err_v_d   = err_v_q;
        capture   = 1'b0;
        case (state_q)
            ST_SEARCH: if (vs_edge) state_d = ST_ALIGN;
            ST_ALIGN: begin
                if (h_bad)        state_d = ST_SEARCH;
                else if (vs_edge) state_d = line_ok ? ST_LOCKED : ST_SEARCH;
            end
            ST_LOCKED: begin
                // Line check before frame check: a coincident pair may flag both.
                if (h_bad) begin
                    err_h_d = 1'b1;
                    state_d = ST_SEARCH;
                end
                if (vs_edge) begin
                    if (line_ok) begin
                        capture = 1'b1;
                    end else begin
                        err_v_d = 1'b1;
                        state_d = ST_SEARCH;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        locked_d      = (state_d == ST_LOCKED);
        frame_valid_d = capture;
        frame_crc_d   = capture ? crc_q : frame_crc_q;
        pixel_count_d = capture ? pix_acc_q : pixel_count_q;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hs_s_q        <= !SYNC_POL;
            vs_s_q        <= !SYNC_POL;
            rgb_s_q       <= '0;
            rgb_a_q       <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            h_per_q       <= '0;
            line_cnt_q    <= '0;
            hs_seen_q     <= 1'b0;
            state_q       <= ST_SEARCH;
            crc_q         <= CRC_INIT;
            pix_acc_q     <= '0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            frame_crc_q   <= '0;
            pixel_count_q <= '0;
        end else begin
            hs_s_q        <= hs_s_d;
            vs_s_q        <= vs_s_d;
            rgb_s_q       <= rgb_s_d;
            rgb_a_q       <= rgb_a_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            h_per_q       <= h_per_d;
            line_cnt_q    <= line_cnt_d;
            hs_seen_q     <= hs_seen_d;
            state_q       <= state_d;
            crc_q         <= crc_d;
            pix_acc_q     <= pix_acc_d;
            locked_q      <= locked_d;
            frame_valid_q <= frame_valid_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
            frame_crc_q   <= frame_crc_d;
            pixel_count_q <= pixel_count_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_crc   = frame_crc_q;
    assign bus.pixel_count = pixel_count_q;
    assign bus.err_h       = err_h_q;
    assign bus.err_v       = err_v_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench on a scaled-down raster; an active-high and an active-low
// monitor watch the same stream and must report identical frames.
module tb_vga_frame_monitor;

    localparam int H_ACT  = 8;
    localparam int H_TOT  = 12;
    localparam int H_SS   = 9;
    localparam int V_ACT  = 6;
    localparam int V_TOT  = 10;
    localparam int V_SS   = 7;
    localparam int SYNC_W = 2;

    typedef struct packed {
        logic [15:0] crc;
        logic [19:0] cnt;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst  = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          rgb_mode = 0;
    logic [15:0] m_crc = 16'hFFFF;
    int          m_cnt = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic        fv0_prev = 1'b0;
    logic        fv1_prev = 1'b0;

    always #5 pclk = ~pclk;

    vga_frame_monitor_if i0 ();
    vga_frame_monitor_if i1 ();

    vga_frame_monitor #(
        .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .H_SYNC_START(H_SS),
        .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT), .V_SYNC_START(V_SS), .SYNC_POL(1'b1)
    ) dut0 (.pclk(pclk), .rst(rst), .bus(i0));

    vga_frame_monitor #(
        .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .H_SYNC_START(H_SS),
        .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT), .V_SYNC_START(V_SS), .SYNC_POL(1'b0)
    ) dut1 (.pclk(pclk), .rst(rst), .bus(i1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference bit-serial CRC-16-CCITT (poly 0x1021), MSB first.
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [31:0] d, input int n);
        logic [15:0] r;
        r = c;
        for (int i = n - 1; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
            else              r = r << 1;
        end
        return r;
    endfunction

    task automatic chk_status(input string tag, input bit lk, input bit eh, input bit ev);
        check({tag, "_locked0"}, 32'(i0.locked), 32'(lk));
        check({tag, "_err_h0"},  32'(i0.err_h),  32'(eh));
        check({tag, "_err_v0"},  32'(i0.err_v),  32'(ev));
        check({tag, "_locked1"}, 32'(i1.locked), 32'(lk));
        check({tag, "_err_h1"},  32'(i1.err_h),  32'(eh));
        check({tag, "_err_v1"},  32'(i1.err_v),  32'(ev));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_locked0"}, 32'(i0.locked),      0);
        check({tag, "_fv0"},     32'(i0.frame_valid), 0);
        check({tag, "_crc0"},    32'(i0.frame_crc),   0);
        check({tag, "_cnt0"},    32'(i0.pixel_count), 0);
        check({tag, "_err_h0"},  32'(i0.err_h),       0);
        check({tag, "_err_v0"},  32'(i0.err_v),       0);
        check({tag, "_locked1"}, 32'(i1.locked),      0);
        check({tag, "_fv1"},     32'(i1.frame_valid), 0);
        check({tag, "_crc1"},    32'(i1.frame_crc),   0);
        check({tag, "_cnt1"},    32'(i1.pixel_count), 0);
        check({tag, "_err_h1"},  32'(i1.err_h),       0);
        check({tag, "_err_v1"},  32'(i1.err_v),       0);
    endtask

    // Drives one frame; push queues the expected report for this frame's vsync,
    // short_line drops one blanking cycle from that line, rst_line pulses reset.
    task automatic gen_frame(input bit push, input int n_lines, input int short_line, input int rst_line);
        int          len;
        bit          hs_a, vs_a, act;
        logic [11:0] pix;
        exp_t        e;
        for (int v = 0; v < n_lines; v++) begin
            len = (v == short_line) ? H_TOT - 1 : H_TOT;
            for (int h = 0; h < len; h++) begin
                if (v == rst_line && h == 8) rst = 1'b1;
                hs_a = (h >= H_SS) && (h < H_SS + SYNC_W);
                vs_a = (v >= V_SS) && (v < V_SS + SYNC_W);
                act  = (h < H_ACT) && (v < V_ACT);
                if (act && rgb_mode == 0)      pix = 12'h000;
                else if (act && rgb_mode == 1) pix = 12'(h);
                else                           pix = 12'($urandom);
                i0.hs_in = hs_a;  i0.vs_in = vs_a;  i0.rgb_in = pix;
                i1.hs_in = !hs_a; i1.vs_in = !vs_a; i1.rgb_in = pix;
                if (v == V_SS && h == 0) begin
                    if (push) begin
                        e.crc = m_crc;
                        e.cnt = 20'(m_cnt);
                        q0.push_back(e);
                        q1.push_back(e);
                    end
                    m_crc = 16'hFFFF;
                    m_cnt = 0;
                end
                if (act) begin
                    m_crc = crc_bits(m_crc, 32'(pix), 12);
                    m_cnt++;
                end
                if (v == rst_line && h == 5) begin
                    #2 rst = 1'b0;
                    #1 chk_reset("midframe_rst");
                end
                @(negedge pclk);
            end
        end
    endtask

    always @(negedge pclk) begin
        if (i0.frame_valid) begin
            check("fv0_width", 32'(fv0_prev), 0);
            check("fv0_queued", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                check("crc0", 32'(i0.frame_crc), 32'(q0[0].crc));
                check("cnt0", 32'(i0.pixel_count), 32'(q0[0].cnt));
                void'(q0.pop_front());
            end
        end
        fv0_prev <= i0.frame_valid;
    end

    always @(negedge pclk) begin
        if (i1.frame_valid) begin
            check("fv1_width", 32'(fv1_prev), 0);
            check("fv1_queued", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                check("crc1", 32'(i1.frame_crc), 32'(q1[0].crc));
                check("cnt1", 32'(i1.pixel_count), 32'(q1[0].cnt));
                void'(q1.pop_front());
            end
        end
        fv1_prev <= i1.frame_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        string       kat;
        logic [15:0] c;
        kat = "123456789";
        c   = 16'hFFFF;
        for (int i = 0; i < kat.len(); i++) c = crc_bits(c, 32'(kat[i]), 8);
        check("model_kat", 32'(c), 32'h29B1);

        i0.hs_in = 1'b0; i0.vs_in = 1'b0; i0.rgb_in = '0;
        i1.hs_in = 1'b1; i1.vs_in = 1'b1; i1.rgb_in = '0;
        repeat (3) @(negedge pclk);
        chk_reset("por");
        rst = 1'b1;
        repeat (4) @(negedge pclk);

        // Clean stream, black pixels: lock at the second vsync, reports after that.
        rgb_mode = 0;
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("f1", 1'b0, 1'b0, 1'b0);
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("f2", 1'b1, 1'b0, 1'b0);
        gen_frame(1'b1, V_TOT, -1, -1);
        gen_frame(1'b1, V_TOT, -1, -1);

        // Horizontal ramp pixels.
        rgb_mode = 1;
        gen_frame(1'b1, V_TOT, -1, -1);
        gen_frame(1'b1, V_TOT, -1, -1);
        chk_status("ramp", 1'b1, 1'b0, 1'b0);

        // One short line: err_h, unlock, relock after two clean vsyncs.
        rgb_mode = 2;
        gen_frame(1'b0, V_TOT, 2, -1);
        chk_status("short_line", 1'b0, 1'b1, 1'b0);
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("relock_h", 1'b1, 1'b1, 1'b0);
        gen_frame(1'b1, V_TOT, -1, -1);

        // One frame short by a line: caught at the following vsync, no report.
        gen_frame(1'b1, V_TOT - 1, -1, -1);
        chk_status("short_frame_pre", 1'b1, 1'b1, 1'b0);
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("short_frame", 1'b0, 1'b1, 1'b1);
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("realign_v", 1'b0, 1'b1, 1'b1);
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("relock_v", 1'b1, 1'b1, 1'b1);
        gen_frame(1'b1, V_TOT, -1, -1);

        // Reset mid-frame: outputs clear at once, one full clean frame to relock.
        gen_frame(1'b0, V_TOT, -1, 3);
        chk_status("post_rst", 1'b0, 1'b0, 1'b0);
        gen_frame(1'b0, V_TOT, -1, -1);
        chk_status("relock_rst", 1'b1, 1'b0, 1'b0);
        gen_frame(1'b1, V_TOT, -1, -1);

        repeat (8) @(negedge pclk);
        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Receive-side counterpart of the XGA video output path. Samples the outgoing `hs`/`vs`/`{r,g,b}` pin-level signals, reconstructs horizontal/vertical position from sync edges, checks line and frame periods against the nominal timing, and computes a per-frame CRC over active pixels. Sits on the pclk domain next to the top level; used in simulation benches and on-chip as a self-check of the draw pipeline.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_TOTAL, 1344, pclk cycles per line
- H_SYNC_START, 1048, hcount at which hsync asserts
- V_ACTIVE, 768, visible lines per frame
- V_TOTAL, 806, lines per frame
- V_SYNC_START, 771, vcount at which vsync asserts
- SYNC_POL, 1, asserted level of hs/vs (1 = active-high)

Ports:
- pclk  in  1  pixel clock (65 MHz); the block's only clock
- rst  in  1  asynchronous, active-low reset
- hs_in  in  1  horizontal sync, pin level
- vs_in  in  1  vertical sync, pin level
- rgb_in  in  12  pixel data {r,g,b}
- locked  out  1  timing verified for at least one full frame
- frame_valid  out  1  one-cycle pulse; frame_crc/pixel_count valid
- frame_crc  out  16  CRC of last complete frame's active pixels
- pixel_count  out  20  active pixels counted in last frame
- err_h  out  1  sticky: line period mismatch while locked
- err_v  out  1  sticky: frame line-count mismatch while locked

## Operation
- Input stage: hs_in, vs_in, rgb_in registered once; all logic below uses registered copies. Sync normalised: asserted = (sample == SYNC_POL).
- Edge detect: hs_edge/vs_edge = asserted now, not asserted previous cycle.
- hcount (11 b): on hs_edge load H_SYNC_START; else increment, wrap H_TOTAL-1 → 0. vcount (10 b): on vs_edge load V_SYNC_START; else increment on hcount wrap, wrap V_TOTAL-1 → 0. vs_edge takes priority over wrap increment.
- h_period counter: cycles between consecutive hs_edges; line_cnt: hs_edges between consecutive vs_edges.
- FSM states SEARCH, ALIGN, LOCKED:
  - SEARCH: wait vs_edge → ALIGN; clear line_cnt, CRC.
  - ALIGN: every hs_edge checks h_period == H_TOTAL; any miss → SEARCH. Next vs_edge: line_cnt == V_TOTAL → LOCKED, else → SEARCH.
  - LOCKED: hs_edge with h_period ≠ H_TOTAL → set err_h, → SEARCH. vs_edge with line_cnt ≠ V_TOTAL → set err_v, → SEARCH. Otherwise stay.
- First hs_edge after a vs_edge is not period-checked if no prior hs_edge has been seen since leaving SEARCH.
- active = hcount < H_ACTIVE and vcount < V_ACTIVE (using counters aligned to registered rgb).
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR; 12 bits per active pixel, bit 11 first (one combinational 12-bit step per cycle). pix_acc counts active pixels.
- On vs_edge in LOCKED with line_cnt == V_TOTAL: frame_crc ← crc, pixel_count ← pix_acc, frame_valid = 1 next cycle; then crc ← 0xFFFF, pix_acc ← 0. On every vs_edge CRC/pix_acc reinitialise.
- err_h/err_v cleared only by reset.

## Timing
- Reset (rst low, async): state SEARCH, locked 0, frame_valid 0, frame_crc 0x0000, pixel_count 0, err_h 0, err_v 0, all counters 0.
- Latency: pin → registered sample 1 cycle; edge detect and counters in the following cycle.
- locked is a registered decode of state == LOCKED; rises the cycle after the qualifying vs_edge, falls the cycle after the failing edge.
- frame_valid: exactly one cycle, one cycle after the vs_edge; frame_crc/pixel_count hold until next update.
- hs_edge and vs_edge in the same cycle: line check first, then frame check; both errors may set.
- Reset mid-frame: immediate return to SEARCH; lock requires one full clean frame after release.

## Structure
- Shared package: XGA timing constants (1024/1344/1048/768/806/771), CRC poly/init constants, FSM state enum.
- One sub-module natural: crc16_12b_step (combinational next-CRC from crc and 12-bit data).

## Test plan
- Clean XGA stream, constant rgb 0x000, 3 frames → locked high after frame 2's vs_edge; frame_valid once per frame; pixel_count 786432; frame_crc equal each frame.
- Same stream with rgb = hcount[11:0] → frame_crc matches software CRC-16-CCITT model, identical across frames.
- Locked, then one line of 1343 cycles → err_h = 1, locked drops next cycle, relocks after 2 clean vs_edges.
- Locked, then frame of 805 lines → err_v = 1, no frame_valid for that frame.
- SYNC_POL = 0 with inverted syncs → same locked/CRC results as scenario 1.
- rst asserted mid-frame 2 → all outputs 0 asynchronously; locked reasserts only after one full clean frame.
